// File: rtl/vga_display_controller_pkg.sv
// Shared VGA timing defaults, bar-colour encoding and pipeline payload type.
package vga_pkg;

  // 640x480 @ 60 Hz
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  // 800x600 @ 72 Hz
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 56;
  localparam int unsigned SVGA800_H_SYNC   = 120;
  localparam int unsigned SVGA800_H_BP     = 64;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 37;
  localparam int unsigned SVGA800_V_SYNC   = 6;
  localparam int unsigned SVGA800_V_BP     = 23;

  localparam int unsigned H_TOTAL = VGA640_H_ACTIVE + VGA640_H_FP + VGA640_H_SYNC + VGA640_H_BP;
  localparam int unsigned V_TOTAL = VGA640_V_ACTIVE + VGA640_V_FP + VGA640_V_SYNC + VGA640_V_BP;

  // {R,G,B} enable bits per bar, left to right
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       tm;
    logic [2:0] bar;
  } pipe_t;

  // Ceiling log2, never below 1 so it can size a vector directly
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [2:0] bar_code(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_code = BAR_WHITE;
      3'd1:    bar_code = BAR_YELLOW;
      3'd2:    bar_code = BAR_MAGENTA;
      3'd3:    bar_code = BAR_RED;
      3'd4:    bar_code = BAR_CYAN;
      3'd5:    bar_code = BAR_GREEN;
      3'd6:    bar_code = BAR_BLUE;
      default: bar_code = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_display_controller_reset_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, releases on the second clk edge.
module reset_sync (
  input  logic clk,
  input  logic arst_n_i,
  output logic rst_n_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge arst_n_i) begin
    if (!arst_n_i) sync_q <= 2'b00;
    else           sync_q <= {sync_q[0], 1'b1};
  end

  assign rst_n_o = sync_q[1];

endmodule

// File: rtl/vga_display_controller.sv
// Programmable VGA timing generator with replicated VRAM addressing, colour bars
// and a delay line that keeps sync/DE/colour aligned with VRAM read data.
module vga_display_controller
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int unsigned H_FP      = VGA640_H_FP,
  parameter int unsigned H_SYNC    = VGA640_H_SYNC,
  parameter int unsigned H_BP      = VGA640_H_BP,
  parameter int unsigned V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int unsigned V_FP      = VGA640_V_FP,
  parameter int unsigned V_SYNC    = VGA640_V_SYNC,
  parameter int unsigned V_BP      = VGA640_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned CW        = 4,
  parameter int unsigned RD_LAT    = 1,
  localparam int unsigned HAW      = clog2(H_ACTIVE >> SCALE),
  localparam int unsigned VAW      = clog2(V_ACTIVE >> SCALE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pix_ce,
  input  logic                 test_mode,
  output logic [HAW+VAW-1:0]   vram_addr,
  input  logic [3*CW-1:0]      vram_data,
  output logic [CW-1:0]        VGA_RED,
  output logic [CW-1:0]        VGA_GREEN,
  output logic [CW-1:0]        VGA_BLUE,
  output logic                 VGA_HSYNC,
  output logic                 VGA_VSYNC,
  output logic                 VGA_DE,
  output logic                 frame_start
);

  localparam int unsigned HT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = clog2(HT + 1);
  localparam int unsigned VW    = clog2(VT + 1);
  localparam int unsigned DL    = RD_LAT + 1;
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned BW    = clog2(BAR_W);

  logic               rst_n;
  logic [HW-1:0]      h_cnt_q, h_cnt_d;
  logic [VW-1:0]      v_cnt_q, v_cnt_d;
  logic [2:0]         bar_idx_q, bar_idx_d;
  logic [BW-1:0]      bar_px_q, bar_px_d;
  logic [HAW+VAW-1:0] vram_addr_q, vram_addr_d;
  pipe_t              dl_q [DL];
  pipe_t              pipe_in, pipe_out;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic [3*CW-1:0]    rgb_q, rgb_d;
  logic               h_wrap, v_wrap, h_act, active;

  reset_sync u_reset_sync (
    .clk      (clk),
    .arst_n_i (reset),
    .rst_n_o  (rst_n)
  );

  // Raster counters, bar tracker and VRAM address
  always_comb begin
    h_wrap      = (h_cnt_q == HW'(HT - 1));
    v_wrap      = (v_cnt_q == VW'(VT - 1));
    h_act       = (h_cnt_q < HW'(H_ACTIVE));
    active      = h_act && (v_cnt_q < VW'(V_ACTIVE));
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    bar_idx_d   = bar_idx_q;
    bar_px_d    = bar_px_q;
    vram_addr_d = vram_addr_q;
    if (pix_ce) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
      if (h_wrap) begin
        bar_idx_d = 3'd0;
        bar_px_d  = '0;
      end else if (h_act) begin
        if (bar_px_q == BW'(BAR_W - 1)) begin
          bar_px_d  = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_px_d  = bar_px_q + BW'(1);
        end
      end
      if (active) vram_addr_d = {VAW'(v_cnt_q >> SCALE), HAW'(h_cnt_q >> SCALE)};
    end
  end

  // Per-pixel attributes entering the delay line (active-high sync flags)
  always_comb begin
    pipe_in     = '0;
    pipe_in.hs  = (h_cnt_q >= HW'(H_ACTIVE + H_FP)) && (h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC));
    pipe_in.vs  = (v_cnt_q >= VW'(V_ACTIVE + V_FP)) && (v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC));
    pipe_in.de  = active;
    pipe_in.tm  = test_mode;
    pipe_in.bar = bar_code(bar_idx_q);
  end

  always_comb begin
    pipe_out = dl_q[DL-1];
    hsync_d  = pipe_out.hs ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = pipe_out.vs ? VSYNC_POL : ~VSYNC_POL;
    de_d     = pipe_out.de;
    rgb_d    = '0;
    if (pipe_out.de) begin
      rgb_d = pipe_out.tm ? {{CW{pipe_out.bar[2]}}, {CW{pipe_out.bar[1]}}, {CW{pipe_out.bar[0]}}}
                          : vram_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      bar_idx_q   <= 3'd0;
      bar_px_q    <= '0;
      vram_addr_q <= '0;
      for (int i = 0; i < DL; i++) dl_q[i] <= '0;
      hsync_q     <= ~HSYNC_POL;
      vsync_q     <= ~VSYNC_POL;
      de_q        <= 1'b0;
      rgb_q       <= '0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      bar_idx_q   <= bar_idx_d;
      bar_px_q    <= bar_px_d;
      vram_addr_q <= vram_addr_d;
      if (pix_ce) begin
        dl_q[0] <= pipe_in;
        for (int i = 1; i < DL; i++) dl_q[i] <= dl_q[i-1];
        hsync_q <= hsync_d;
        vsync_q <= vsync_d;
        de_q    <= de_d;
        rgb_q   <= rgb_d;
      end
    end
  end

  // Marks counter state (0,0), not the pins
  assign frame_start = rst_n && pix_ce && (h_cnt_q == '0) && (v_cnt_q == '0);

  assign vram_addr = vram_addr_q;
  assign VGA_RED   = rgb_q[3*CW-1 -: CW];
  assign VGA_GREEN = rgb_q[2*CW-1 -: CW];
  assign VGA_BLUE  = rgb_q[CW-1:0];
  assign VGA_HSYNC = hsync_q;
  assign VGA_VSYNC = vsync_q;
  assign VGA_DE    = de_q;

endmodule

// File: tb/tb_vga_display_controller.sv
// Directed bench for vga_display_controller on a reduced 32x16 raster with RD_LAT=2.
module tb_vga_display_controller;

  localparam int unsigned H_ACT = 32, H_FPO = 2, H_SY = 3, H_BPO = 3, H_TOT = 40;
  localparam int unsigned V_ACT = 16, V_FPO = 1, V_SY = 2, V_BPO = 1, V_TOT = 20;
  localparam int unsigned FRAME = H_TOT * V_TOT;
  localparam int unsigned LAT   = 4;
  localparam int          LIMIT = 10000;

  logic        clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0, test_mode = 1'b0;
  logic [4:0]  vram_addr;
  logic [11:0] vram_data;
  logic [3:0]  red, green, blue;
  logic        hsync, vsync, de, fs;
  logic [4:0]  mem1 = '0, mem2 = '0;

  int          vec_cnt = 0, err_cnt = 0;
  int          k = 0, n = 0, cyc = 0;
  logic [4:0]  addr_exp = '0;
  bit          tm_at [8192];

  vga_display_controller #(
    .H_ACTIVE(H_ACT), .H_FP(H_FPO), .H_SYNC(H_SY), .H_BP(H_BPO),
    .V_ACTIVE(V_ACT), .V_FP(V_FPO), .V_SYNC(V_SY), .V_BP(V_BPO),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .SCALE(2), .CW(4), .RD_LAT(2)
  ) dut (
    .clk(clk), .reset(rst_n), .pix_ce(pix_ce), .test_mode(test_mode),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .VGA_RED(red), .VGA_GREEN(green), .VGA_BLUE(blue),
    .VGA_HSYNC(hsync), .VGA_VSYNC(vsync), .VGA_DE(de), .frame_start(fs)
  );

  always #5 clk = ~clk;

  // Two-tick VRAM returning its own address as data
  always @(posedge clk) if (pix_ce) begin
    mem1 <= vram_addr;
    mem2 <= mem1;
  end
  assign vram_data = {7'd0, mem2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", tag, got, exp, n);
    end
  endtask

  task automatic check_pins();
    int m, h, v;
    logic e_hs, e_vs, e_de, e_fs;
    logic [2:0] code;
    logic [11:0] e_rgb;
    e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_rgb = '0;
    if (n >= int'(LAT)) begin
      m = n - int'(LAT);
      h = m % H_TOT;
      v = (m / H_TOT) % V_TOT;
      e_de = (h < H_ACT) && (v < V_ACT);
      e_hs = !((h >= H_ACT + H_FPO) && (h < H_ACT + H_FPO + H_SY));
      e_vs = !((v >= V_ACT + V_FPO) && (v < V_ACT + V_FPO + V_SY));
      if (e_de) begin
        if (tm_at[m]) begin
          code  = 3'(7 - h / 4);
          e_rgb = {{4{code[2]}}, {4{code[1]}}, {4{code[0]}}};
        end else begin
          e_rgb = 12'((v / 4) * 8 + h / 4);
        end
      end
    end
    e_fs = (k >= 2) && pix_ce && (n % FRAME == 0);
    check("hsync", 32'(hsync), 32'(e_hs));
    check("vsync", 32'(vsync), 32'(e_vs));
    check("de", 32'(de), 32'(e_de));
    check("rgb", {20'd0, red, green, blue}, 32'(e_rgb));
    check("frame_start", 32'(fs), 32'(e_fs));
    check("vram_addr", 32'(vram_addr), 32'(addr_exp));
  endtask

  // One clk: drive inputs, advance the bench's tick count, then check at negedge
  task automatic cycle(input logic tm, input logic pce);
    int h, v;
    test_mode = tm;
    pix_ce    = pce;
    @(posedge clk);
    cyc++;
    if (rst_n) k++;
    if (k >= 3 && pce) begin
      tm_at[n] = tm;
      h = n % H_TOT;
      v = (n / H_TOT) % V_TOT;
      if (h < H_ACT && v < V_ACT) addr_exp = 5'((v / 4) * 8 + h / 4);
      n++;
    end
    @(negedge clk);
    check_pins();
  endtask

  initial begin
    logic ph;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);

    rst_n = 1'b1;
    while (n < 172 && cyc < LIMIT) cycle(1'b0, 1'b1);
    check("px_8_4", {20'd0, red, green, blue}, 32'h00A);
    check("de_8_4", 32'(de), 32'd1);
    while (n < 175 && cyc < LIMIT) cycle(1'b0, 1'b1);
    check("px_11_4", {20'd0, red, green, blue}, 32'h00A);
    cycle(1'b0, 1'b1);
    check("px_12_4", {20'd0, red, green, blue}, 32'h00B);
    while (n < int'(FRAME) && cyc < LIMIT) cycle(1'b0, 1'b1);

    while (n < int'(FRAME) + 4 && cyc < LIMIT) cycle(1'b1, 1'b1);
    check("bar_white", {20'd0, red, green, blue}, 32'hFFF);
    while (n < int'(FRAME) + 16 && cyc < LIMIT) cycle(1'b1, 1'b1);
    check("bar_red", {20'd0, red, green, blue}, 32'hF00);
    while (n < int'(FRAME) + 24 && cyc < LIMIT) cycle(1'b1, 1'b1);
    check("bar_green", {20'd0, red, green, blue}, 32'h0F0);
    while (n < int'(FRAME) + 32 && cyc < LIMIT) cycle(1'b1, 1'b1);
    check("bar_black", {20'd0, red, green, blue}, 32'h000);
    while (n < 2 * int'(FRAME) && cyc < LIMIT) cycle(1'b1, 1'b1);

    ph = 1'b1;
    while (n < 3 * int'(FRAME) && cyc < LIMIT) begin
      cycle(1'b0, ph);
      ph = ~ph;
    end

    while (n < 3 * int'(FRAME) + 2 * int'(H_TOT) + 10 && cyc < LIMIT) cycle(1'b1, 1'b1);
    check("bar_yellow_mid", {20'd0, red, green, blue}, 32'hFF0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hsync", 32'(hsync), 32'd1);
    check("arst_vsync", 32'(vsync), 32'd1);
    check("arst_de", 32'(de), 32'd0);
    check("arst_rgb", {20'd0, red, green, blue}, 32'h000);
    check("arst_addr", 32'(vram_addr), 32'd0);
    check("arst_fs", 32'(fs), 32'd0);
    @(negedge clk);
    k = 0; n = 0; addr_exp = '0;
    rst_n = 1'b1;
    while (n < 4 && cyc < LIMIT) cycle(1'b1, 1'b1);
    check("restart_px0", {20'd0, red, green, blue}, 32'hFFF);
    while (n < 50 && cyc < LIMIT) cycle(1'b1, 1'b1);

    check("cycle_budget", 32'(cyc < LIMIT), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/vga_display_controller.md
# vga_display_controller

Parametrised VGA display controller. It is the next-generation replacement for the fixed 1-bit, fixed-mode top-level controller. It generates programmable horizontal and vertical timing and pixel-replicated frame-buffer addresses for an external synchronous VRAM with configurable read latency. It emits pipeline-aligned HSYNC, VSYNC, data-enable and multi-bit RGB, with a built-in colour-bar test mode.

## Interface
- H_ACTIVE, 640, visible pixels per line; must be a multiple of 8 and of 2^SCALE
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines; must be a multiple of 2^SCALE
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of each sync output
- SCALE, 2, log2 of the pixel-replication factor (frame buffer is H_ACTIVE>>SCALE by V_ACTIVE>>SCALE)
- CW, 4, bits per colour channel
- RD_LAT, 1, VRAM read latency in pix_ce ticks (1..4)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel-rate clock enable; the whole block advances only when it is 1
- test_mode  in  1  0 = VRAM pixels, 1 = colour bars (sampled per pixel)
- vram_addr  out  HAW+VAW  {row, col} read address; HAW = clog2(H_ACTIVE>>SCALE), VAW = clog2(V_ACTIVE>>SCALE)
- vram_data  in  3*CW  {R,G,B} returned RD_LAT ticks after vram_addr
- VGA_RED / VGA_GREEN / VGA_BLUE  out  CW each  colour outputs
- VGA_HSYNC / VGA_VSYNC  out  1  sync outputs
- VGA_DE  out  1  data enable (active video)
- frame_start  out  1  one-clk pulse in the pix_ce cycle where h_cnt=0 and v_cnt=0

## Operation
- Reset is asserted asynchronously and deasserted synchronously through a 2-flop synchroniser. All state below uses the synchronised reset.
- Counter h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. Counter v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps. Both counters wrap to 0 and hold when pix_ce=0.
- Active region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- hsync_raw is active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vsync_raw uses the same rule on v_cnt. Output level = POL when active, else ~POL.
- vram_addr is registered: {v_cnt>>SCALE, h_cnt>>SCALE} when in the active region, held at its last value otherwise.
- Colour bars: a bar counter (0..7) advances every H_ACTIVE/8 active pixels and resets at h_cnt=0. No divider is used.
  - Bar b gives R = all ones if b[2], G = all ones if b[1], B = all ones if b[0], else zero.
- Output stage selects test_mode ? bar colour : vram_data. It forces RGB to 0 when DE=0.
- Sync, DE and bar colour pass through a delay line of length 1+RD_LAT so they align with vram_data.

## Timing
- Reset values (asserted, and for 2 clk after deassertion): h_cnt=v_cnt=0, vram_addr=0, RGB=0, DE=0, frame_start=0, HSYNC=~HSYNC_POL, VSYNC=~VSYNC_POL, all delay-line stages inactive.
- Latency from counter state to pins is LAT = RD_LAT+2 pix_ce ticks, identical for RGB, sync and DE.
- Reset mid-frame returns all outputs to reset values within the same clk (async). Timing restarts at h_cnt=0.
- test_mode changing mid-line takes effect on the next pixel. No glitch appears on sync or DE.
- frame_start marks the counter state, not the pin state. Pins show pixel (0,0) LAT ticks later.
- Sync is not re-derived from RGB. Porch widths of 0 are legal, except that H_SYNC and V_SYNC must be ≥1.

## Structure
- Shared package vga_pkg holds:
  - the timing-parameter defaults (640x480@60, 800x600@72)
  - function clog2
  - localparams H_TOTAL and V_TOTAL
  - the bar-colour encoding constants
- Sub-module reset_sync (2-flop, async assert, sync deassert) is instantiated once.
- Counters, delay line and output mux live in the top module.

## Test plan
- Hold reset low, toggle clk → HSYNC=VSYNC=1 (POL=0), DE=0, RGB=0, vram_addr=0. Release reset → first counter advance occurs on the 3rd clk edge.
- Defaults, pix_ce=1 → HSYNC low for exactly 96 clks starting 656+LAT clks after frame_start. Period is 800 clks. DE high for 640 clks per line.
- Run a full frame → VSYNC low for 2 lines starting at line 490. frame_start period is 420000 clks.
- pix_ce toggling 1,0,1,0 → all periods double. Outputs change only after pix_ce=1 cycles.
- RD_LAT=2, VRAM model returns data = address → RGB at pixel (8,4) equals the address word {1,2} and is aligned with DE. Pixels 8..11 share one address.
- test_mode=1 → 8 bars of 80 pixels: white, yellow, magenta, red, cyan, green, blue, black. Assert reset low mid-line → outputs return to reset values immediately.
